// File: rtl/pushbutton_capture.sv
// Push-button capture: synchronizes and debounces four active-low keys, then latches
// sticky press flags and a wrapping press count into a 32-bit status word.
module pushbutton_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  key_n,
    input  logic        ack_toggle,
    output logic [31:0] buttons_word
);

    localparam logic [23:0] CntMax = 24'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  level;
    logic [3:0]  stable_q;
    logic [3:0]  stable_d;
    logic [23:0] cnt_q [4];
    logic [23:0] cnt_d [4];
    logic [3:0]  press;
    logic [3:0]  sticky_q;
    logic [3:0]  sticky_d;
    logic [7:0]  press_cnt_q;
    logic [7:0]  press_cnt_d;
    logic        ack_prev_q;
    logic        ack_clear;

    assign level     = ~sync2_q;
    assign ack_clear = ack_toggle != ack_prev_q;

    // Press is derived from the stable-level update itself so flag and count land on the same edge.
    always_comb begin
        stable_d = stable_q;
        press    = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (level[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = level[i];
                    press[i]    = level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 24'd1;
                end
            end
        end
    end

    // A press on the same edge as an ack clear must survive the clear.
    always_comb begin
        sticky_d    = (ack_clear ? 4'b0000 : sticky_q) | press;
        press_cnt_d = press_cnt_q;
        for (int i = 0; i < 4; i++) begin
            press_cnt_d = press_cnt_d + 8'(press[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            stable_q    <= '0;
            sticky_q    <= '0;
            press_cnt_q <= '0;
            ack_prev_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            sticky_q    <= sticky_d;
            press_cnt_q <= press_cnt_d;
            ack_prev_q  <= ack_toggle;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign buttons_word = {16'h0000, press_cnt_q, sticky_q, stable_q};

endmodule

// File: tb/tb_pushbutton_capture.sv
// Directed bench for pushbutton_capture with a short debounce window of 4 cycles.
module tb_pushbutton_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  key_n;
    logic        ack_toggle;
    logic [31:0] buttons_word;

    int n_checks = 0;
    int n_fail   = 0;

    pushbutton_capture #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .ack_toggle  (ack_toggle),
        .buttons_word(buttons_word)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (buttons_word === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, buttons_word, exp);
        end
    endtask

    task automatic do_ack();
        ack_toggle = ~ack_toggle;
        tick(1);
    endtask

    initial begin
        reset_n    = 1'b0;
        key_n      = 4'hF;
        ack_toggle = 1'b0;
        tick(3);
        check("reset_word", 32'h0000_0000);
        reset_n = 1'b1;
        tick(3);
        check("idle_after_reset", 32'h0000_0000);

        // Key 0 held: visible after exactly 6 edges.
        key_n = 4'hE;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            check($sformatf("k0_press_edge%0d", e), 32'h0000_0000);
        end
        tick(1);
        check("k0_press_edge6", 32'h0000_0111);

        key_n = 4'hF;
        tick(5);
        check("k0_release_edge5", 32'h0000_0111);
        tick(1);
        check("k0_release_edge6", 32'h0000_0110);
        do_ack();
        check("ack_clear_k0", 32'h0000_0100);

        // Key 2 glitch of 3 cycles is rejected.
        key_n = 4'hB;
        tick(3);
        key_n = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check($sformatf("k2_glitch_%0d", e), 32'h0000_0100);
        end

        // Key 1 bounces every 2 cycles for 20 cycles, then held.
        for (int b = 0; b < 5; b++) begin
            key_n = 4'hD;
            tick(2);
            key_n = 4'hF;
            tick(2);
            check($sformatf("k1_bounce_%0d", b), 32'h0000_0100);
        end
        key_n = 4'hD;
        tick(10);
        check("k1_held", 32'h0000_0222);
        key_n = 4'hF;
        tick(8);
        check("k1_released", 32'h0000_0220);
        do_ack();
        check("ack_clear_k1", 32'h0000_0200);

        // All four keys together.
        key_n = 4'h0;
        tick(5);
        check("all_press_edge5", 32'h0000_0200);
        tick(1);
        check("all_press_edge6", 32'h0000_06FF);
        key_n = 4'hF;
        tick(5);
        check("all_release_edge5", 32'h0000_06FF);
        tick(1);
        check("all_release_edge6", 32'h0000_06F0);

        // Second key-3 press coincides with an ack clear.
        key_n = 4'h7;
        tick(5);
        check("k3_before_collide", 32'h0000_06F0);
        ack_toggle = ~ack_toggle;
        tick(1);
        check("k3_press_with_ack", 32'h0000_0788);
        key_n = 4'hF;
        tick(6);
        check("k3_released", 32'h0000_0780);
        do_ack();
        check("ack_clear_k3", 32'h0000_0700);

        // Reset clears everything; then 256 presses wrap the counter.
        reset_n = 1'b0;
        #1;
        check("reset_async", 32'h0000_0000);
        tick(2);
        ack_toggle = 1'b0;
        reset_n    = 1'b1;
        tick(1);
        for (int p = 0; p < 256; p++) begin
            key_n = 4'hE;
            tick(6);
            key_n = 4'hF;
            tick(6);
            do_ack();
            check($sformatf("wrap_press_%0d", p), {16'h0000, 8'(p + 1), 8'h00});
        end
        check("wrap_final", 32'h0000_0000);

        // Reset mid-debounce with key released before reset ends: no event.
        key_n = 4'hE;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("mid_debounce_reset", 32'h0000_0000);
        key_n = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check("no_event_after_release", 32'h0000_0000);

        // Key held across reset: reported and counted after 6 edges.
        key_n = 4'hE;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("held_reset_word", 32'h0000_0000);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("held_after_reset_edge5", 32'h0000_0000);
        tick(1);
        check("held_after_reset_edge6", 32'h0000_0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pushbutton_capture.md
PUSHBUTTON_CAPTURE -- requirements
Module: pushbutton_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clk cycles required to accept a button level change (20 ms at 50 MHz); the legal range SHALL be 2..2^24-1.
REQ-002 Port clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port key_n  input  4  raw board push buttons, active-low, asynchronous to clk.
REQ-005 Port ack_toggle  input  1  host acknowledge, synchronous to clk, driven from a bit of the red LED PIO output; every level change clears the sticky flags.
REQ-006 Port buttons_word  output  32  status word feeding the push-button PIO input of the PCIe core.

Function
REQ-007 Each key_n bit SHALL pass through a 2-flop synchronizer, then be inverted, so that 1 = pressed.
REQ-008 Each button SHALL have a stable level register and a 24-bit debounce counter.
REQ-009 When the synchronized level equals the stable level, that button's counter SHALL clear to 0.
REQ-010 When the levels differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-011 When the levels differ and the counter equals DEBOUNCE_CYCLES-1, the stable level SHALL take the synchronized value and the counter SHALL clear in the same edge.
REQ-012 A clean key_n edge SHALL appear in stable level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-013 Any glitch shorter than DEBOUNCE_CYCLES cycles, measured after synchronization, SHALL leave stable level unchanged.
REQ-014 A press event SHALL be a stable level 0->1 transition; release transitions SHALL produce no event.
REQ-015 Each press event SHALL set that button's sticky flag.
REQ-016 Sticky flags SHALL stay set until ack_toggle differs from its previous-cycle registered value; all four flags then clear on the next edge.
REQ-017 When a press event and an ack clear occur on the same edge, the flag of the pressing button SHALL end set, and all other flags SHALL clear.
REQ-018 An 8-bit press counter SHALL add the number of press events on each edge (0..4).
REQ-019 The press counter SHALL wrap modulo 256 and SHALL NOT be cleared by ack.
REQ-020 buttons_word[3:0] SHALL be the stable levels.
REQ-021 buttons_word[7:4] SHALL be the sticky flags.
REQ-022 buttons_word[15:8] SHALL be the press counter.
REQ-023 buttons_word[31:16] SHALL be 0.
REQ-024 Bit i of each field SHALL correspond to key_n[i].
REQ-025 buttons_word SHALL be driven only from registers, with no combinational path from any input.

Reset
REQ-026 While reset_n=0, synchronizer flops SHALL be 1 (released), stable levels 0, debounce counters 0, sticky flags 0, press counter 0, and the ack_toggle previous-value register 0.
REQ-027 While reset_n=0, buttons_word SHALL be 0x00000000.
REQ-028 Reset assertion mid-debounce SHALL discard partial counts.
REQ-029 After reset release, a button already held SHALL be reported pressed after DEBOUNCE_CYCLES+2 cycles and SHALL generate a press event.
REQ-030 If ack_toggle=1 at reset release, the first edge SHALL perform a clear, which is harmless because all flags are 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Scenario: key_n[0] held low from cycle 0 -> buttons_word = 0x00000111 after edge 6; 0x00000000 on edges 1-5.
REQ-032 Scenario: key_n[2] pulsed low for 3 cycles -> buttons_word remains 0x00000000 throughout.
REQ-033 Scenario: key_n[1] bounces low/high every 2 cycles for 20 cycles, then held low -> exactly one press event, count=1, word 0x00000122.
REQ-034 Scenario: all four keys pressed on the same cycle and held -> word 0x000004FF; release all -> word 0x000004F0 after 6 edges.
REQ-035 Scenario: flags 0xF set, ack_toggle toggles on the same edge that key 3 registers a second press -> flags = 0x8, count incremented by 1.
REQ-036 Scenario: 256 presses of key 0, each followed by ack -> count wraps to 0x00; reset_n pulsed low mid-debounce -> word 0x00000000 immediately and no event after release unless the key is still held.
